digital_lock_system: RTL and testbench

Two-stage combination lock driven by eight slide switches. Entering CODE1 arms the lock. Entering CODE2 within a timeout window then opens it. Timeout, or a tamper pattern (all switches on), latches an alarm that only reset clears. Internal detector, timer and mux signals are exported as debug/observation ports for board LEDs and verification.

---
 rtl/digital_lock_system_pkg.sv | 24 ++
 rtl/digital_lock_system_lock_timer.sv | 36 +++
 rtl/digital_lock_system.sv | 97 +++++++++
 tb/tb_digital_lock_system.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/digital_lock_system_pkg.sv
// Shared types and default constants for the two-stage combination lock.
package digital_lock_system_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait2 = 3'd1,
    StOpen  = 3'd2,
    StAlarm = 3'd3
  } lock_state_e;

  localparam logic [7:0] DefaultCode1 = 8'h0F;
  localparam logic [7:0] DefaultCode2 = 8'hF0;
  localparam logic [7:0] TamperCode   = 8'hFF;
  localparam logic [7:0] RelockCode   = 8'h00;

  localparam int unsigned DefaultTimeoutCycles = 16;
  localparam int unsigned DefaultCntW          = 5;

  // States in which the window timer runs.
  function automatic logic is_timed_state(lock_state_e s);
    return (s == StWait2) || (s == StOpen);
  endfunction

endpackage

// File: rtl/digital_lock_system_lock_timer.sv
// Window timer: restarts on every state change, counts while enabled, saturates at the limit.
module digital_lock_system_lock_timer #(
  parameter int unsigned TimeoutCycles = 16,
  parameter int unsigned CntW          = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [CntW-1:0] Limit = CntW'(TimeoutCycles);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (restart_i || !en_i) begin
      count_d = '0;
    end else if (count_q < Limit) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_o = (count_q >= Limit);

endmodule

// File: rtl/digital_lock_system.sv
// Two-stage combination lock: CODE1 arms, CODE2 within the window opens; timeout or tamper alarms.
module digital_lock_system
  import digital_lock_system_pkg::*;
#(
  parameter logic [7:0]  CODE1          = DefaultCode1,
  parameter logic [7:0]  CODE2          = DefaultCode2,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  parameter int unsigned CNT_W          = DefaultCntW
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  input  logic       s4,
  input  logic       s5,
  input  logic       s6,
  input  logic       s7,
  output logic       alarm,
  output logic       locked,
  output logic [2:0] curr_state,
  output logic       det1,
  output logic       det2,
  output logic       timeout,
  output logic       allsw,
  output logic       mux_out
);

  logic [7:0]  sw;
  logic        relock_sw;
  lock_state_e state_q, state_d;

  assign sw        = {s7, s6, s5, s4, s3, s2, s1, s0};
  assign det1      = (sw == CODE1);
  assign det2      = (sw == CODE2);
  assign allsw     = (sw == TamperCode);
  assign relock_sw = (sw == RelockCode);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (allsw)     state_d = StAlarm;
        else if (det1) state_d = StWait2;
      end
      StWait2: begin
        if (allsw)        state_d = StAlarm;
        else if (det2)    state_d = StOpen;
        else if (timeout) state_d = StAlarm;
      end
      StOpen: begin
        if (allsw)          state_d = StAlarm;
        else if (relock_sw) state_d = StIdle;
        else if (timeout)   state_d = StIdle;
      end
      StAlarm: state_d = StAlarm;
      // Encodings 4..7 recover to IDLE.
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  digital_lock_system_lock_timer #(
    .TimeoutCycles(TIMEOUT_CYCLES),
    .CntW         (CNT_W)
  ) u_lock_timer (
    .clk_i    (clk),
    .rst_ni   (clear),
    .restart_i(state_d != state_q),
    .en_i     (is_timed_state(state_q)),
    .timeout_o(timeout)
  );

  assign curr_state = state_q;
  assign alarm      = (state_q == StAlarm);
  assign locked     = (state_q != StOpen);

  always_comb begin
    mux_out = 1'b0;
    unique case (state_q[1:0])
      2'd0: mux_out = det1;
      2'd1: mux_out = det2;
      2'd2: mux_out = timeout;
      2'd3: mux_out = allsw;
      default: mux_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_digital_lock_system.sv
// Scoreboard bench for digital_lock_system: each step pushes the expected post-edge view.
module tb_digital_lock_system;

  typedef struct packed {
    logic [2:0] st;
    logic       lk;
    logic       al;
    logic       to;
    logic       d1;
    logic       d2;
    logic       ff;
    logic       mux;
  } obs_t;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       alarm, locked, det1, det2, timeout, allsw, mux_out;
  logic [2:0] curr_state;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  digital_lock_system dut (
    .clk       (clk),
    .clear     (clear),
    .s0        (sw[0]),
    .s1        (sw[1]),
    .s2        (sw[2]),
    .s3        (sw[3]),
    .s4        (sw[4]),
    .s5        (sw[5]),
    .s6        (sw[6]),
    .s7        (sw[7]),
    .alarm     (alarm),
    .locked    (locked),
    .curr_state(curr_state),
    .det1      (det1),
    .det2      (det2),
    .timeout   (timeout),
    .allsw     (allsw),
    .mux_out   (mux_out)
  );

  function automatic obs_t exp_obs(logic [7:0] s, logic [2:0] st, logic to);
    obs_t o;
    o.st = st;
    o.lk = (st != 3'd2);
    o.al = (st == 3'd3);
    o.to = to;
    o.d1 = (s == 8'h0F);
    o.d2 = (s == 8'hF0);
    o.ff = (s == 8'hFF);
    case (st[1:0])
      2'd0: o.mux = o.d1;
      2'd1: o.mux = o.d2;
      2'd2: o.mux = o.to;
      default: o.mux = o.ff;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {curr_state, locked, alarm, timeout, det1, det2, allsw, mux_out};
    return o;
  endfunction

  // Drive inputs mid-cycle, record the expected view after the next edge, then wait past it.
  task automatic drive_step(input logic [7:0] s, input logic clr, input logic [2:0] st,
                            input logic to);
    @(negedge clk);
    sw    = s;
    clear = clr;
    exp_q.push_back(exp_obs(s, st, to));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int i = 0; i < 3; i++) begin
      drive_step(8'h00, (i == 2), 3'd0, 1'b0);
      got = sample();
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset step %0d: got {st,lk,al,to,d1,d2,ff,mux}=%b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_unlock();
    obs_t got, exp;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 1, 2, 3: drive_step(8'h0F, 1'b1, 3'd1, 1'b0);
        4:          drive_step(8'hF0, 1'b1, 3'd2, 1'b0);
        default:    drive_step(8'h00, 1'b1, 3'd0, 1'b0);
      endcase
      got = sample();
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL unlock step %0d: got {st,lk,al,to,d1,d2,ff,mux}=%b want %b", i, got, exp);
      end
    end
  endtask

  // det2 arriving on the same edge as timeout must still open the lock.
  task automatic test_det2_vs_timeout();
    obs_t got, exp;
    for (int i = 0; i < 19; i++) begin
      if (i == 0)       drive_step(8'h0F, 1'b1, 3'd1, 1'b0);
      else if (i <= 16) drive_step(8'h33, 1'b1, 3'd1, (i >= 16));
      else if (i == 17) drive_step(8'hF0, 1'b1, 3'd2, 1'b0);
      else              drive_step(8'h00, 1'b1, 3'd0, 1'b0);
      got = sample();
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL det2_vs_timeout step %0d: got {st,lk,al,to,d1,d2,ff,mux}=%b want %b",
                 i, got, exp);
      end
    end
  endtask

  task automatic test_timeout_alarm();
    obs_t got, exp;
    for (int i = 0; i < 68; i++) begin
      if (i == 0)       drive_step(8'h0F, 1'b1, 3'd1, 1'b0);
      else if (i <= 16) drive_step(8'h0F, 1'b1, 3'd1, (i >= 16));
      else if (i == 17) drive_step(8'h0F, 1'b1, 3'd3, 1'b0);
      else              drive_step(8'($urandom), 1'b1, 3'd3, 1'b0);
      got = sample();
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL timeout_alarm step %0d: got {st,lk,al,to,d1,d2,ff,mux}=%b want %b",
                 i, got, exp);
      end
    end
  endtask

  task automatic test_reset_from_alarm();
    obs_t got, exp;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive_step(8'hFF, 1'b0, 3'd0, 1'b0);
        1:       drive_step(8'h0F, 1'b1, 3'd1, 1'b0);
        2:       drive_step(8'h00, 1'b1, 3'd1, 1'b0);
        default: drive_step(8'h00, 1'b0, 3'd0, 1'b0);
      endcase
      got = sample();
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_from_alarm step %0d: got {st,lk,al,to,d1,d2,ff,mux}=%b want %b",
                 i, got, exp);
      end
    end
  endtask

  task automatic test_tamper();
    obs_t got, exp;
    logic [7:0] s_tab  [10] = '{8'hFF, 8'h00, 8'h0F, 8'hFF, 8'h00,
                                8'h0F, 8'hF0, 8'hFF, 8'h00, 8'h00};
    logic       c_tab  [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] st_tab [10] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
    for (int i = 0; i < 10; i++) begin
      drive_step(s_tab[i], c_tab[i], st_tab[i], 1'b0);
      got = sample();
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL tamper step %0d: got {st,lk,al,to,d1,d2,ff,mux}=%b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_auto_relock();
    obs_t got, exp;
    for (int i = 0; i < 19; i++) begin
      if (i == 0)       drive_step(8'h0F, 1'b1, 3'd1, 1'b0);
      else if (i == 1)  drive_step(8'hF0, 1'b1, 3'd2, 1'b0);
      else if (i <= 17) drive_step(8'hF0, 1'b1, 3'd2, (i - 1 >= 16));
      else              drive_step(8'hF0, 1'b1, 3'd0, 1'b0);
      got = sample();
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL auto_relock step %0d: got {st,lk,al,to,d1,d2,ff,mux}=%b want %b",
                 i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_det2_vs_timeout();
    test_timeout_alarm();
    test_reset_from_alarm();
    test_tamper();
    test_auto_relock();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
